add_reservation_station: RTL and testbench
==========================================

Name: add_reservation_station

Overview:
- Reservation station plus pipelined adder for the ADD functional unit, directly downstream of the register table in the Tomasulo core.
- Accepts one issued ADD/SUB per cycle with operands as either values or producer tags.
- Snoops the ADD and MUL common data buses to wake waiting entries and dispatches the oldest ready entry to the adder.
- Broadcasts results on ADD_Tag_op/ADD_Output, which feed back to the register table and to all reservation stations.

Parameters:
- NUM_ENTRIES, 3, number of RS entries (1..3); entry i owns tag TAG_BASE+i.
- TAG_BASE, 3'b001, tag of entry 0; ADD tags are 3'b001..3'b011.
- ADD_LATENCY, 2, adder pipeline registers from dispatch to broadcast (>=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- issue_valid  input  1  issue request this cycle
- issue_sub  input  1  0 = a+b, 1 = a-b
- src1_tag  input  3  producer tag of operand a; 0 = src1_val is valid
- src1_val  input  8  operand a value
- src2_tag  input  3  producer tag of operand b; 0 = src2_val is valid
- src2_val  input  8  operand b value
- issue_ready  output  1  at least one free entry
- alloc_tag  output  3  tag the next issue will get (drives register table ADD_Tag_ip); 0 when full
- MUL_Tag_op  input  3  MUL CDB tag; 0 = no broadcast
- MUL_Output  input  8  MUL CDB value
- ADD_Tag_op  output  3  ADD CDB tag; 0 = no broadcast
- ADD_Output  output  8  ADD CDB value
- busy  output  NUM_ENTRIES  per-entry occupied flags

Behaviour:
- Reset (sync, active-high): all entries cleared and pipeline flushed. Outputs: ADD_Tag_op=0, ADD_Output=0, busy=0. issue_ready=0 while reset is high, 1 afterwards; alloc_tag=TAG_BASE afterwards. Issue is ignored during reset.
- Reset mid-operation discards in-flight results; no broadcast follows.
- Entry fields: busy, dispatched, sub, q1/v1, q2/v2, age.
- Issue: accepted at the edge where issue_valid && issue_ready, into the lowest-index free entry. alloc_tag = TAG_BASE + that index (combinational). issue_valid while full is ignored, with no state change.
- Issue-time bypass: if srcN_tag is nonzero and equals a nonzero ADD_Tag_op or MUL_Tag_op in the same cycle, capture that bus value and store qN=0.
- Wakeup: each cycle, any busy entry with qN equal to a nonzero bus tag captures the value and clears qN. Both operands may wake in the same cycle from the same or different buses. The ADD bus wakes this station's own entries.
- Ready: busy && !dispatched && q1==0 && q2==0, evaluated on registered state. An entry woken in cycle b is first eligible in cycle b+1.
- Select: one dispatch per cycle, oldest issued ready entry (age ordering, not index). Selected entry is marked dispatched at the edge.
- Adder: fully pipelined, ADD_LATENCY stages. Result is (v1+v2) or (v1-v2) mod 256, no flags.
- Timing:
  - Ready-at-issue instruction issued in cycle t broadcasts in cycle t+1+ADD_LATENCY.
  - Instruction woken in cycle b broadcasts in b+1+ADD_LATENCY.
- Broadcast: ADD_Tag_op=entry tag and ADD_Output=result for exactly one cycle. Otherwise both are 0. Back-to-back dispatches give back-to-back broadcasts.
- Entry free: busy clears at the edge ending its broadcast cycle. The tag is reallocatable from the next cycle, never during its own broadcast cycle.
- A broadcast on MUL_Tag_op equal to one of this station's tags is treated as an ordinary wakeup (no special case).
- Tags not held by any entry have no effect.

Test Plan:
- Reset; cycle 0 issue 5+3 (tags 0) -> alloc_tag=1; cycle 3 ADD_Tag_op=1, ADD_Output=8; cycle 4 ADD_Tag_op=0; busy[0] clears after cycle 3.
- Issue src1_tag=3'b100, src2_val=2; MUL bus tag 3'b100 value 20 in cycle 5 -> dispatch cycle 6; cycle 8 ADD_Tag_op=1, ADD_Output=22.
- Fill all three entries waiting on MUL tag 3'b101 -> issue_ready=0, alloc_tag=0, 4th issue ignored. After the tag 3'b101 broadcast, three results appear on consecutive cycles in issue order (tags 1,2,3).
- Chain: A=1+1 (tag 1), then B=tag1+4 -> B woken by A's own broadcast; B result 6 on tag 2 exactly 3 cycles after A's broadcast.
- Issue with src2_tag=3'b110 in the same cycle MUL bus shows tag 3'b110 value 9 -> operand captured; 1+9 result 10 broadcast at t+3.
- Issue 3-5 with sub -> ADD_Output=8'hFE. Separately, assert reset one cycle after dispatch -> no broadcast follows, busy=0.

Source files
------------

// File: rtl/add_reservation_station.sv
// ADD/SUB reservation station feeding a pipelined adder that drives the ADD common data bus.
// Latency: issue-to-broadcast 1+ADD_LATENCY cycles once operands are ready. Backpressure: issue_ready low when all entries are busy.
module add_reservation_station #(
    parameter int         NUM_ENTRIES = 3,
    parameter logic [2:0] TAG_BASE    = 3'b001,
    parameter int         ADD_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic                   issue_sub,
    input  logic [2:0]             src1_tag,
    input  logic [7:0]             src1_val,
    input  logic [2:0]             src2_tag,
    input  logic [7:0]             src2_val,
    output logic                   issue_ready,
    output logic [2:0]             alloc_tag,
    input  logic [2:0]             MUL_Tag_op,
    input  logic [7:0]             MUL_Output,
    output logic [2:0]             ADD_Tag_op,
    output logic [7:0]             ADD_Output,
    output logic [NUM_ENTRIES-1:0] busy
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int AW = $clog2(NUM_ENTRIES) + 1;

    logic [NUM_ENTRIES-1:0] r_busy;
    logic [NUM_ENTRIES-1:0] r_disp;
    logic [NUM_ENTRIES-1:0] r_sub;
    logic [2:0]             r_q1  [NUM_ENTRIES];
    logic [7:0]             r_v1  [NUM_ENTRIES];
    logic [2:0]             r_q2  [NUM_ENTRIES];
    logic [7:0]             r_v2  [NUM_ENTRIES];
    logic [AW-1:0]          r_age [NUM_ENTRIES];
    logic [2:0]             r_pipe_tag [ADD_LATENCY];
    logic [7:0]             r_pipe_dat [ADD_LATENCY];

    logic                   w_free_found;
    logic [IW-1:0]          w_alloc_idx;
    logic                   w_issue_fire;
    logic [2:0]             w_iq1, w_iq2;
    logic [7:0]             w_iv1, w_iv2;
    logic [2:0]             w_q1_wk [NUM_ENTRIES];
    logic [7:0]             w_v1_wk [NUM_ENTRIES];
    logic [2:0]             w_q2_wk [NUM_ENTRIES];
    logic [7:0]             w_v2_wk [NUM_ENTRIES];
    logic                   w_sel_vld;
    logic [NUM_ENTRIES-1:0] w_sel_oh;
    logic [AW-1:0]          w_sel_age;
    logic [2:0]             w_sel_tag;
    logic [7:0]             w_sel_res;

    function automatic logic [2:0] entry_tag(input int idx);
        return TAG_BASE + 3'(idx);
    endfunction

    function automatic logic bus_hit(input logic [2:0] q, input logic [2:0] bus_tag);
        return (q != 3'd0) && (q == bus_tag);
    endfunction

    // Lowest-index free entry receives the next issue.
    always_comb begin
        w_free_found = 1'b0;
        w_alloc_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_alloc_idx  = IW'(i);
            end
        end
    end

    assign issue_ready  = !reset && w_free_found;
    assign alloc_tag    = w_free_found ? (TAG_BASE + 3'(w_alloc_idx)) : 3'd0;
    assign w_issue_fire = issue_valid && issue_ready;

    always_comb begin
        w_iq1 = src1_tag;
        w_iv1 = src1_val;
        w_iq2 = src2_tag;
        w_iv2 = src2_val;
        if (bus_hit(src1_tag, ADD_Tag_op)) begin
            w_iq1 = 3'd0;
            w_iv1 = ADD_Output;
        end else if (bus_hit(src1_tag, MUL_Tag_op)) begin
            w_iq1 = 3'd0;
            w_iv1 = MUL_Output;
        end
        if (bus_hit(src2_tag, ADD_Tag_op)) begin
            w_iq2 = 3'd0;
            w_iv2 = ADD_Output;
        end else if (bus_hit(src2_tag, MUL_Tag_op)) begin
            w_iq2 = 3'd0;
            w_iv2 = MUL_Output;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_q1_wk[i] = r_q1[i];
            w_v1_wk[i] = r_v1[i];
            w_q2_wk[i] = r_q2[i];
            w_v2_wk[i] = r_v2[i];
            if (bus_hit(r_q1[i], ADD_Tag_op)) begin
                w_q1_wk[i] = 3'd0;
                w_v1_wk[i] = ADD_Output;
            end else if (bus_hit(r_q1[i], MUL_Tag_op)) begin
                w_q1_wk[i] = 3'd0;
                w_v1_wk[i] = MUL_Output;
            end
            if (bus_hit(r_q2[i], ADD_Tag_op)) begin
                w_q2_wk[i] = 3'd0;
                w_v2_wk[i] = ADD_Output;
            end else if (bus_hit(r_q2[i], MUL_Tag_op)) begin
                w_q2_wk[i] = 3'd0;
                w_v2_wk[i] = MUL_Output;
            end
        end
    end

    // Oldest ready entry wins; readiness uses registered operands only, so wakeup costs one cycle.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_oh  = '0;
        w_sel_age = '0;
        w_sel_tag = 3'd0;
        w_sel_res = 8'd0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_busy[i] && !r_disp[i] && (r_q1[i] == 3'd0) && (r_q2[i] == 3'd0) &&
                (!w_sel_vld || (r_age[i] > w_sel_age))) begin
                w_sel_vld   = 1'b1;
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_age   = r_age[i];
                w_sel_tag   = entry_tag(i);
                w_sel_res   = r_sub[i] ? (r_v1[i] - r_v2[i]) : (r_v1[i] + r_v2[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_disp <= '0;
            r_sub  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_q1[i]  <= 3'd0;
                r_v1[i]  <= 8'd0;
                r_q2[i]  <= 3'd0;
                r_v2[i]  <= 8'd0;
                r_age[i] <= '0;
            end
            for (int s = 0; s < ADD_LATENCY; s++) begin
                r_pipe_tag[s] <= 3'd0;
                r_pipe_dat[s] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_q1[i] <= w_q1_wk[i];
                r_v1[i] <= w_v1_wk[i];
                r_q2[i] <= w_q2_wk[i];
                r_v2[i] <= w_v2_wk[i];
                if (w_sel_oh[i]) begin
                    r_disp[i] <= 1'b1;
                end
                // Age counts later issues; saturation keeps relative order among live entries.
                if (r_busy[i] && w_issue_fire && (r_age[i] != '1)) begin
                    r_age[i] <= r_age[i] + AW'(1);
                end
                if (r_busy[i] && (ADD_Tag_op == entry_tag(i))) begin
                    r_busy[i] <= 1'b0;
                    r_disp[i] <= 1'b0;
                end
                if (w_issue_fire && (w_alloc_idx == IW'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_disp[i] <= 1'b0;
                    r_sub[i]  <= issue_sub;
                    r_q1[i]   <= w_iq1;
                    r_v1[i]   <= w_iv1;
                    r_q2[i]   <= w_iq2;
                    r_v2[i]   <= w_iv2;
                    r_age[i]  <= '0;
                end
            end
            r_pipe_tag[0] <= w_sel_vld ? w_sel_tag : 3'd0;
            r_pipe_dat[0] <= w_sel_vld ? w_sel_res : 8'd0;
            for (int s = 1; s < ADD_LATENCY; s++) begin
                r_pipe_tag[s] <= r_pipe_tag[s-1];
                r_pipe_dat[s] <= r_pipe_dat[s-1];
            end
        end
    end

    assign ADD_Tag_op = r_pipe_tag[ADD_LATENCY-1];
    assign ADD_Output = r_pipe_dat[ADD_LATENCY-1];
    assign busy       = r_busy;

endmodule

// File: tb/tb_add_reservation_station.sv
// Scoreboard bench for add_reservation_station: expected broadcasts are queued at issue time
// and matched against the ADD bus (cycle, tag, value) on every falling edge.
module tb_add_reservation_station;
    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_sub;
    logic [2:0] src1_tag;
    logic [7:0] src1_val;
    logic [2:0] src2_tag;
    logic [7:0] src2_val;
    logic       issue_ready;
    logic [2:0] alloc_tag;
    logic [2:0] MUL_Tag_op;
    logic [7:0] MUL_Output;
    logic [2:0] ADD_Tag_op;
    logic [7:0] ADD_Output;
    logic [2:0] busy;

    always #5 clk = ~clk;

    add_reservation_station #(
        .NUM_ENTRIES(3),
        .TAG_BASE   (3'b001),
        .ADD_LATENCY(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_sub  (issue_sub),
        .src1_tag   (src1_tag),
        .src1_val   (src1_val),
        .src2_tag   (src2_tag),
        .src2_val   (src2_val),
        .issue_ready(issue_ready),
        .alloc_tag  (alloc_tag),
        .MUL_Tag_op (MUL_Tag_op),
        .MUL_Output (MUL_Output),
        .ADD_Tag_op (ADD_Tag_op),
        .ADD_Output (ADD_Output),
        .busy       (busy)
    );

    typedef struct {
        int         cyc;
        logic [2:0] tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                chk("bc_missing_cycle", cyc, mon_e.cyc);
            end
            if (ADD_Tag_op != 3'd0) begin
                if (sb_q.size() == 0) begin
                    chk("bc_spurious_tag", ADD_Tag_op, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("bc_cycle", cyc, mon_e.cyc);
                    chk("bc_tag", ADD_Tag_op, mon_e.tag);
                    chk("bc_value", ADD_Output, mon_e.val);
                end
            end else begin
                chk("idle_out", ADD_Output, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        issue_valid = 1'b0;
        issue_sub   = 1'b0;
        src1_tag    = 3'd0;
        src1_val    = 8'd0;
        src2_tag    = 3'd0;
        src2_val    = 8'd0;
        MUL_Tag_op  = 3'd0;
        MUL_Output  = 8'd0;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic issue(input logic s, input logic [2:0] t1, input logic [7:0] v1,
                         input logic [2:0] t2, input logic [7:0] v2);
        issue_valid = 1'b1;
        issue_sub   = s;
        src1_tag    = t1;
        src1_val    = v1;
        src2_tag    = t2;
        src2_val    = v2;
    endtask

    task automatic expect_bc(input int c, input logic [2:0] t, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = t;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 30) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("sb_empty", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_tag", ADD_Tag_op, 0);
        chk("rst_add_out", ADD_Output, 0);
        reset = 1'b0;
        #1;
        cyc = 0;
        chk("post_rst_ready", issue_ready, 1);
        chk("post_rst_alloc", alloc_tag, 3'b001);
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_sub   = 1'b0;
        src1_tag    = 3'd0;
        src1_val    = 8'd0;
        src2_tag    = 3'd0;
        src2_val    = 8'd0;
        MUL_Tag_op  = 3'd0;
        MUL_Output  = 8'd0;
        step();
        mon_en = 1'b1;

        // Ready-at-issue add and entry lifetime
        do_reset();
        issue(1'b0, 3'd0, 8'd5, 3'd0, 8'd3);
        expect_bc(3, 3'd1, 8'd8);
        step();
        chk("s1_busy_c1", busy, 3'b001);
        chk("s1_alloc_c1", alloc_tag, 3'd2);
        go_to(3);
        chk("s1_busy_c3", busy, 3'b001);
        step();
        chk("s1_busy_c4", busy, 3'b000);
        chk("s1_alloc_c4", alloc_tag, 3'd1);
        drain();

        // Wakeup from the MUL bus
        do_reset();
        issue(1'b0, 3'b100, 8'd0, 3'd0, 8'd2);
        go_to(5);
        MUL_Tag_op = 3'b100;
        MUL_Output = 8'd20;
        expect_bc(8, 3'd1, 8'd22);
        drain();

        // Full station, rejected issue, oldest-first drain
        do_reset();
        issue(1'b0, 3'b101, 8'd0, 3'd0, 8'd1);
        step();
        issue(1'b0, 3'b101, 8'd0, 3'd0, 8'd2);
        step();
        issue(1'b1, 3'b101, 8'd0, 3'd0, 8'd3);
        step();
        chk("s3_ready_full", issue_ready, 0);
        chk("s3_alloc_full", alloc_tag, 0);
        chk("s3_busy_full", busy, 3'b111);
        issue(1'b0, 3'd0, 8'd7, 3'd0, 8'd7);
        step();
        chk("s3_busy_hold", busy, 3'b111);
        go_to(5);
        MUL_Tag_op = 3'b101;
        MUL_Output = 8'd20;
        expect_bc(8, 3'd1, 8'd21);
        expect_bc(9, 3'd2, 8'd22);
        expect_bc(10, 3'd3, 8'd17);
        drain();

        // Dependent chain woken by the station's own broadcast
        do_reset();
        issue(1'b0, 3'd0, 8'd1, 3'd0, 8'd1);
        expect_bc(3, 3'd1, 8'd2);
        step();
        chk("s4_alloc_c1", alloc_tag, 3'd2);
        issue(1'b0, 3'd1, 8'd0, 3'd0, 8'd4);
        expect_bc(6, 3'd2, 8'd6);
        drain();

        // Issue-time bypass from the ADD bus
        do_reset();
        issue(1'b0, 3'd0, 8'd1, 3'd0, 8'd1);
        expect_bc(3, 3'd1, 8'd2);
        go_to(3);
        issue(1'b0, 3'd1, 8'd0, 3'd0, 8'd4);
        expect_bc(6, 3'd2, 8'd6);
        drain();

        // Issue-time bypass from the MUL bus
        do_reset();
        MUL_Tag_op = 3'b110;
        MUL_Output = 8'd9;
        issue(1'b0, 3'd0, 8'd1, 3'b110, 8'd0);
        expect_bc(3, 3'd1, 8'd10);
        drain();

        // Subtract wraps modulo 256
        do_reset();
        issue(1'b1, 3'd0, 8'd3, 3'd0, 8'd5);
        expect_bc(3, 3'd1, 8'hFE);
        drain();

        // Age beats index when a lower entry is reused later
        do_reset();
        issue(1'b0, 3'd0, 8'd1, 3'd0, 8'd1);
        expect_bc(3, 3'd1, 8'd2);
        step();
        issue(1'b0, 3'b101, 8'd0, 3'd0, 8'd10);
        go_to(4);
        chk("s8_alloc_reuse", alloc_tag, 3'd1);
        issue(1'b0, 3'b101, 8'd0, 3'd0, 8'd20);
        go_to(6);
        MUL_Tag_op = 3'b101;
        MUL_Output = 8'd1;
        expect_bc(9, 3'd2, 8'd11);
        expect_bc(10, 3'd1, 8'd21);
        drain();

        // Reset after dispatch discards the in-flight result
        do_reset();
        issue(1'b0, 3'd0, 8'd1, 3'd0, 8'd2);
        go_to(2);
        reset = 1'b1;
        step();
        chk("s7_tag_after_rst", ADD_Tag_op, 0);
        chk("s7_busy_after_rst", busy, 0);
        reset = 1'b0;
        repeat (5) step();
        chk("s7_busy_later", busy, 0);
        chk("s7_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
